// File: rtl/cdb_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_issue_arbiter
// Purpose  : Issues reservation-queue heads to their FUs and books the CDB
//            cycle each result returns in, then muxes the due FU onto the CDB.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_issue_arbiter #(
   parameter int INT_LAT  = 1,
   parameter int LDST_LAT = 2,
   parameter int MULT_LAT = 4,
   parameter int DIV_LAT  = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        int_empty,
   input  logic        ldst_empty,
   input  logic        mult_empty,
   input  logic        div_empty,
   input  logic        int_ready,
   input  logic        ldst_ready,
   input  logic        mult_ready,
   input  logic        div_ready,
   output logic        int_rd,
   output logic        ldst_rd,
   output logic        mult_rd,
   output logic        div_rd,
   input  logic [5:0]  int_tag,
   input  logic [5:0]  ldst_tag,
   input  logic [5:0]  mult_tag,
   input  logic [5:0]  div_tag,
   input  logic [31:0] int_data,
   input  logic [31:0] ldst_data,
   input  logic [31:0] mult_data,
   input  logic [31:0] div_data,
   input  logic        int_branch,
   input  logic        int_branch_taken,
   output logic        cdb_valid,
   output logic [5:0]  cdb_tag,
   output logic [31:0] cdb_data,
   output logic        cdb_branch,
   output logic        cdb_branch_taken,
   output logic        div_busy
);

   localparam int c_LAT [4] = '{INT_LAT, LDST_LAT, MULT_LAT, DIV_LAT};
   localparam logic [1:0] c_ID_INT = 2'd0;
   localparam logic [1:0] c_ID_DIV = 2'd3;

   localparam bit c_RANGE_OK = (INT_LAT  >= 1) && (INT_LAT  <= 15) &&
                               (LDST_LAT >= 1) && (LDST_LAT <= 15) &&
                               (MULT_LAT >= 1) && (MULT_LAT <= 15) &&
                               (DIV_LAT  >= 1) && (DIV_LAT  <= 15);
   localparam bit c_DISTINCT = (INT_LAT  != LDST_LAT) && (INT_LAT  != MULT_LAT) &&
                               (INT_LAT  != DIV_LAT)  && (LDST_LAT != MULT_LAT) &&
                               (LDST_LAT != DIV_LAT)  && (MULT_LAT != DIV_LAT);

   generate
      if (!(c_RANGE_OK && c_DISTINCT)) begin : g_bad_lat
         $error("cdb_issue_arbiter: latencies must be distinct and within 1..15");
      end
   endgenerate

   // Slot 0 is the CDB slot being broadcast this cycle; slot k broadcasts k
   // cycles from now. An issue this cycle lands in slot LAT-1 after the shift,
   // so it is free exactly when the current slot LAT is free.
   logic [14:0] r_vld;
   logic [1:0]  r_id [15];
   logic [3:0]  r_div_cnt;

   logic [3:0]  w_empty;
   logic [3:0]  w_ready;
   logic [3:0]  w_free;
   logic [3:0]  w_rd;

   assign w_empty = {div_empty, mult_empty, ldst_empty, int_empty};
   assign w_ready = {div_ready, mult_ready, ldst_ready, int_ready};
   assign div_busy = (r_div_cnt != 4'd0);

   generate
      for (genvar g = 0; g < 4; g++) begin : g_fu
         if (c_LAT[g] == 15) begin : g_top
            assign w_free[g] = 1'b1;
         end else begin : g_slot
            assign w_free[g] = ~r_vld[c_LAT[g]];
         end
         if (g == 3) begin : g_div
            assign w_rd[g] = i_rst_n & ~w_empty[g] & w_ready[g] & w_free[g] & ~div_busy;
         end else begin : g_pipe
            assign w_rd[g] = i_rst_n & ~w_empty[g] & w_ready[g] & w_free[g];
         end
      end
   endgenerate

   assign int_rd  = w_rd[0];
   assign ldst_rd = w_rd[1];
   assign mult_rd = w_rd[2];
   assign div_rd  = w_rd[3];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_vld     <= '0;
         r_div_cnt <= 4'd0;
         for (int k = 0; k < 15; k++) begin
            r_id[k] <= 2'd0;
         end
      end else begin
         for (int k = 0; k < 14; k++) begin
            r_vld[k] <= r_vld[k+1];
            r_id[k]  <= r_id[k+1];
         end
         r_vld[14] <= 1'b0;
         r_id[14]  <= 2'd0;
         for (int f = 0; f < 4; f++) begin
            if (w_rd[f]) begin
               r_vld[c_LAT[f]-1] <= 1'b1;
               r_id[c_LAT[f]-1]  <= 2'(f);
            end
         end
         if (w_rd[3]) begin
            r_div_cnt <= 4'(DIV_LAT - 1);
         end else if (r_div_cnt != 4'd0) begin
            r_div_cnt <= r_div_cnt - 4'd1;
         end
      end
   end

   always_comb begin
      cdb_valid        = r_vld[0];
      cdb_tag          = 6'd0;
      cdb_data         = 32'd0;
      cdb_branch       = 1'b0;
      cdb_branch_taken = 1'b0;
      if (r_vld[0]) begin
         case (r_id[0])
            2'd0:    begin cdb_tag = int_tag;  cdb_data = int_data;  end
            2'd1:    begin cdb_tag = ldst_tag; cdb_data = ldst_data; end
            2'd2:    begin cdb_tag = mult_tag; cdb_data = mult_data; end
            default: begin cdb_tag = div_tag;  cdb_data = div_data;  end
         endcase
         if (r_id[0] == c_ID_INT) begin
            cdb_branch       = int_branch;
            cdb_branch_taken = int_branch_taken;
         end
      end
   end

   logic w_unused;
   assign w_unused = (c_ID_DIV == 2'd3);

endmodule
`default_nettype wire

// File: tb/tb_cdb_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_issue_arbiter
// Purpose  : Randomized scoreboard bench; a cycle-booking model predicts every
//            pop and every CDB broadcast.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_issue_arbiter;

   localparam int c_LAT [4] = '{1, 2, 4, 8};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  emp, rdy;
   logic [5:0]  ftag [4];
   logic [31:0] fdat [4];
   logic        ib, ibt;
   logic        int_rd, ldst_rd, mult_rd, div_rd;
   logic        cdb_valid, cdb_branch, cdb_branch_taken, div_busy;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   bit started = 1'b0;

   typedef struct { int due; int id; } exp_t;
   exp_t sbq [$];
   int   booked [int];
   int   div_free = 0;

   always #5 clk = ~clk;

   cdb_issue_arbiter dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .int_empty(emp[0]), .ldst_empty(emp[1]), .mult_empty(emp[2]), .div_empty(emp[3]),
      .int_ready(rdy[0]), .ldst_ready(rdy[1]), .mult_ready(rdy[2]), .div_ready(rdy[3]),
      .int_rd(int_rd), .ldst_rd(ldst_rd), .mult_rd(mult_rd), .div_rd(div_rd),
      .int_tag(ftag[0]), .ldst_tag(ftag[1]), .mult_tag(ftag[2]), .div_tag(ftag[3]),
      .int_data(fdat[0]), .ldst_data(fdat[1]), .mult_data(fdat[2]), .div_data(fdat[3]),
      .int_branch(ib), .int_branch_taken(ibt),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_branch_taken),
      .div_busy(div_busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
      end
   endtask

   // Model: a broadcast cycle is either booked or free; div is free again
   // DIV_LAT cycles after it issued.
   task automatic model_cycle();
      logic [3:0] act_rd;
      act_rd = {div_rd, mult_rd, ldst_rd, int_rd};
      if (!rst_n) begin
         chk("rd_in_reset", 32'(act_rd), 32'd0);
         chk("div_busy_in_reset", 32'(div_busy), 32'd0);
         sbq.delete();
         booked.delete();
         div_free = 0;
         return;
      end
      chk("div_busy", 32'(div_busy), 32'(cyc < div_free));
      for (int f = 0; f < 4; f++) begin
         bit exp_rd;
         exp_rd = !emp[f] && rdy[f] && !booked.exists(cyc + c_LAT[f]) &&
                  (f != 3 || cyc >= div_free);
         chk($sformatf("rd%0d", f), 32'(act_rd[f]), 32'(exp_rd));
         if (exp_rd) begin
            exp_t e;
            booked[cyc + c_LAT[f]] = f;
            if (f == 3) div_free = cyc + c_LAT[3];
            e.due = cyc + c_LAT[f];
            e.id  = f;
            sbq.push_back(e);
            sbq.sort() with (item.due);
         end
      end
   endtask

   always @(negedge clk) begin
      if (started && rst_n) begin
         bit   exp_v;
         exp_t e;
         while (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            chk("lost_broadcast_due", 32'(e.due), 32'(cyc));
         end
         exp_v = (sbq.size() > 0) && (sbq[0].due == cyc);
         chk("cdb_valid", 32'(cdb_valid), 32'(exp_v));
         if (exp_v) begin
            e = sbq.pop_front();
            chk("cdb_tag", 32'(cdb_tag), 32'(ftag[e.id]));
            chk("cdb_data", cdb_data, fdat[e.id]);
            chk("cdb_branch", 32'(cdb_branch), 32'(e.id == 0 && ib));
            chk("cdb_branch_taken", 32'(cdb_branch_taken), 32'(e.id == 0 && ibt));
         end else begin
            chk("idle_cdb", {cdb_tag, cdb_branch, cdb_branch_taken}, 32'd0);
            chk("idle_data", cdb_data, 32'd0);
         end
      end else if (started) begin
         chk("cdb_in_reset", {cdb_valid, cdb_tag, cdb_branch, cdb_branch_taken}, 32'd0);
         chk("cdb_data_in_reset", cdb_data, 32'd0);
      end
   end

   task automatic drive(input bit all_go, input int ready_pct);
      for (int f = 0; f < 4; f++) begin
         emp[f]  = all_go ? 1'b0 : ($urandom_range(99) < 20);
         rdy[f]  = all_go ? 1'b1 : ($urandom_range(99) < ready_pct);
         ftag[f] = 6'($urandom);
         fdat[f] = $urandom;
      end
      ib  = 1'($urandom);
      ibt = 1'($urandom);
   endtask

   task automatic run(input int n, input int ready_pct, input bit burst_first);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         #1;
         drive(burst_first && i == 0, ready_pct);
         @(negedge clk);
         model_cycle();
      end
   endtask

   initial begin
      drive(1'b0, 0);
      emp = 4'hF;
      rdy = 4'h0;
      started = 1'b1;
      run(3, 70, 1'b0);
      @(posedge clk); cyc++; #1; rst_n = 1'b1; drive(1'b1, 100);
      @(negedge clk); model_cycle();
      run(400, 90, 1'b0);
      run(400, 35, 1'b0);
      // asynchronous reset arriving mid-cycle with results in flight
      @(posedge clk); cyc++; #1; drive(1'b0, 90);
      @(negedge clk); model_cycle();
      #2 rst_n = 1'b0;
      run(3, 90, 1'b0);
      @(posedge clk); cyc++; #1; rst_n = 1'b1; drive(1'b1, 100);
      @(negedge clk); model_cycle();
      run(600, 60, 1'b0);
      run(20, 0, 1'b0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
